// File: rtl/memory_rtl_param.sv
// Parameterised word memory with byte-enable writes, fixed-latency reads and
// a one-cycle response/error handshake; register-based so reset clears every word.
module memory_rtl_param #(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_SIZE    = 16,
    parameter int                    RD_LATENCY  = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic                      rd,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   be,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      response,
    output logic                      error,
    output logic                      busy
);

    localparam int                   NUM_BYTES = DATA_WIDTH / 8;
    localparam int                   CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP_RD
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic                    response_reg, response_next;
    logic                    error_reg, error_next;

    logic                    write_en;
    logic                    addr_bad;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   word_q [MEM_SIZE];

    assign addr_bad = ({1'b0, addr} >= (ADDR_WIDTH + 1)'(MEM_SIZE));

    // In IDLE the read target is the live address (latency-1 reads); afterwards the captured one.
    assign rd_addr = (state_reg == IDLE) ? addr : addr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < MEM_SIZE; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_reg;
            logic                  word_we;

            assign word_we    = write_en && (addr == ADDR_WIDTH'(gi));
            assign word_q[gi] = word_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_reg <= RESET_VALUE;
                end else if (word_we) begin
                    for (int b = 0; b < NUM_BYTES; b++) begin
                        if (be[b]) begin
                            word_reg[8*b +: 8] <= wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        rd_word = RESET_VALUE;
        for (int i = 0; i < MEM_SIZE; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_word = word_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            rdata_reg    <= RESET_VALUE;
            response_reg <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            rdata_reg    <= rdata_next;
            response_reg <= response_next;
            error_reg    <= error_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        rdata_next    = rdata_reg;
        response_next = 1'b0;
        error_next    = 1'b0;
        write_en      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (wr || rd) begin
                    if ((wr && rd) || addr_bad) begin
                        response_next = 1'b1;
                        error_next    = 1'b1;
                    end else if (wr) begin
                        write_en      = 1'b1;
                        response_next = 1'b1;
                    end else begin
                        addr_next = addr;
                        if (RD_LATENCY == 1) begin
                            state_next    = RESP_RD;
                            response_next = 1'b1;
                            rdata_next    = rd_word;
                        end else begin
                            state_next = RD_WAIT;
                            cnt_next   = CNT_WIDTH'(1);
                        end
                    end
                end
            end

            // cnt_reg counts edges since accept; the response register is loaded on the last one.
            RD_WAIT: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next    = RESP_RD;
                    cnt_next      = '0;
                    response_next = 1'b1;
                    rdata_next    = rd_word;
                end else begin
                    cnt_next = cnt_reg + CNT_WIDTH'(1);
                end
            end

            RESP_RD: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rdata    = rdata_reg;
    assign response = response_reg;
    assign error    = error_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_memory_rtl_param.sv
// Bench for memory_rtl_param: four configurations share one stimulus bus selected by sel;
// a behavioural model predicts every response (error, rdata, cycle) into a scoreboard queue.
module tb_memory_rtl_param;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [31:0] cyc;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr, rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  sel;

    logic [3:0]  wr_i, rd_i;
    logic [31:0] rdata_o [4];
    logic [3:0]  resp_o, err_o, busy_o;
    logic [31:0] rdata_m;
    logic        response_m, error_m, busy_m;

    logic [31:0] cyc = '0;
    int          passed = 0;
    int          total = 0;
    int          qual_errs = 0;

    resp_t       exp_q[$];
    resp_t       obs_q[$];
    resp_t       e, o;

    logic [31:0] model [4][16];
    logic [31:0] last_rd [4];
    logic [31:0] busy_until [4];
    int          msize [4] = '{16, 12, 16, 16};
    int          lat [4]   = '{2, 2, 4, 1};
    logic [31:0] rv [4]    = '{32'h0, 32'h0, 32'h5A5AA5A5, 32'h0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        wr_i = '0;
        rd_i = '0;
        wr_i[sel] = wr;
        rd_i[sel] = rd;
        rdata_m    = rdata_o[sel];
        response_m = resp_o[sel];
        error_m    = err_o[sel];
        busy_m     = busy_o[sel];
    end

    memory_rtl_param u_dflt (
        .clk(clk), .reset(reset), .wr(wr_i[0]), .rd(rd_i[0]), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata_o[0]), .response(resp_o[0]), .error(err_o[0]), .busy(busy_o[0])
    );
    memory_rtl_param #(.MEM_SIZE(12)) u_m12 (
        .clk(clk), .reset(reset), .wr(wr_i[1]), .rd(rd_i[1]), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata_o[1]), .response(resp_o[1]), .error(err_o[1]), .busy(busy_o[1])
    );
    memory_rtl_param #(.RD_LATENCY(4), .RESET_VALUE(32'h5A5AA5A5)) u_l4 (
        .clk(clk), .reset(reset), .wr(wr_i[2]), .rd(rd_i[2]), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata_o[2]), .response(resp_o[2]), .error(err_o[2]), .busy(busy_o[2])
    );
    memory_rtl_param #(.RD_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .wr(wr_i[3]), .rd(rd_i[3]), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata_o[3]), .response(resp_o[3]), .error(err_o[3]), .busy(busy_o[3])
    );

    // Records what the selected DUT produced; comparisons happen in the test tasks.
    always @(negedge clk) begin
        if (response_m) obs_q.push_back('{error_m, rdata_m, cyc});
        if ((err_o & ~resp_o) != 4'b0000) qual_errs++;
    end

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int a = 0; a < 16; a++) model[k][a] = rv[k];
            last_rd[k]    = rv[k];
            busy_until[k] = '0;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Presents one request for one cycle (called at a falling edge) and predicts its response.
    task automatic issue(input logic w, input logic r, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        resp_t x;
        wr = w; rd = r; addr = a; wdata = d; be = b;
        if ((w || r) && cyc >= busy_until[sel]) begin
            if ((w && r) || a >= msize[sel]) begin
                x = '{1'b1, last_rd[sel], cyc + 1};
            end else if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) model[sel][a][8*i +: 8] = d[8*i +: 8];
                x = '{1'b0, last_rd[sel], cyc + 1};
            end else begin
                last_rd[sel]    = model[sel][a];
                x               = '{1'b0, model[sel][a], cyc + lat[sel]};
                busy_until[sel] = cyc + lat[sel] + 1;
            end
            exp_q.push_back(x);
        end
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        wr = 1'b0; rd = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        while (cyc < busy_until[sel]) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({rdata_o[k], resp_o[k], err_o[k], busy_o[k]} !== {rv[k], 3'b000})
                $display("FAIL reset_state[%0d]: got rdata=%h resp=%b err=%b busy=%b, expected rdata=%h resp=0 err=0 busy=0",
                         k, rdata_o[k], resp_o[k], err_o[k], busy_o[k], rv[k]);
            else begin
                passed++;
                $display("reset_state[%0d]: rdata=%h ok", k, rdata_o[k]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_read_latency();
        logic [2:0] pat;
        sel = 2'd0;
        pat = 3'b011;
        issue(1'b0, 1'b1, 4'd5, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (busy_m !== pat[i])
                $display("FAIL read_busy[%0d]: got %b, expected %b", i, busy_m, pat[i]);
            else passed++;
            @(negedge clk);
        end
        idle(2);
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL read_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e)
                $display("FAIL read_resp: got err=%b rdata=%h cycle=%0d, expected err=%b rdata=%h cycle=%0d",
                         o.err, o.data, o.cyc, e.err, e.data, e.cyc);
            else begin passed++; $display("read: err=%b rdata=%h cycle=%0d ok", o.err, o.data, o.cyc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_byte_enable();
        sel = 2'd0;
        issue(1'b1, 1'b0, 4'd3, 32'hAABBCCDD, 4'hF);
        issue(1'b1, 1'b0, 4'd3, 32'h11223344, 4'b0101);
        issue(1'b0, 1'b1, 4'd3, 32'h0, 4'h0);
        wait_ready();
        issue(1'b1, 1'b0, 4'd3, 32'hFFFFFFFF, 4'h0);
        issue(1'b0, 1'b1, 4'd3, 32'h0, 4'h0);
        idle(4);
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL byte_en_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e)
                $display("FAIL byte_en_resp: got err=%b rdata=%h cycle=%0d, expected err=%b rdata=%h cycle=%0d",
                         o.err, o.data, o.cyc, e.err, e.data, e.cyc);
            else begin passed++; $display("byte_en: err=%b rdata=%h cycle=%0d ok", o.err, o.data, o.cyc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reject();
        sel = 2'd1;
        issue(1'b1, 1'b0, 4'd2,  32'hCAFEF00D, 4'hF);
        issue(1'b1, 1'b0, 4'd13, 32'h13131313, 4'hF);
        issue(1'b1, 1'b0, 4'd12, 32'h12121212, 4'hF);
        issue(1'b1, 1'b0, 4'd11, 32'h12345678, 4'hF);
        issue(1'b0, 1'b1, 4'd13, 32'h0, 4'h0);
        issue(1'b1, 1'b1, 4'd2,  32'hDEADDEAD, 4'hF);
        issue(1'b0, 1'b1, 4'd2,  32'h0, 4'h0);
        wait_ready();
        issue(1'b1, 1'b0, 4'd14, 32'h14141414, 4'hF);
        issue(1'b0, 1'b1, 4'd11, 32'h0, 4'h0);
        idle(5);
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL reject_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e)
                $display("FAIL reject_resp: got err=%b rdata=%h cycle=%0d, expected err=%b rdata=%h cycle=%0d",
                         o.err, o.data, o.cyc, e.err, e.data, e.cyc);
            else begin passed++; $display("reject: err=%b rdata=%h cycle=%0d ok", o.err, o.data, o.cyc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_busy_ignore();
        sel = 2'd0;
        issue(1'b1, 1'b0, 4'd1, 32'h01010101, 4'hF);
        issue(1'b0, 1'b1, 4'd1, 32'h0, 4'h0);
        issue(1'b1, 1'b0, 4'd1, 32'hBAD0BAD0, 4'hF);
        issue(1'b1, 1'b0, 4'd1, 32'hBAD1BAD1, 4'hF);
        issue(1'b0, 1'b1, 4'd1, 32'h0, 4'h0);
        idle(5);
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL busy_ignore_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e)
                $display("FAIL busy_ignore_resp: got err=%b rdata=%h cycle=%0d, expected err=%b rdata=%h cycle=%0d",
                         o.err, o.data, o.cyc, e.err, e.data, e.cyc);
            else begin passed++; $display("busy_ignore: err=%b rdata=%h cycle=%0d ok", o.err, o.data, o.cyc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_latency_one();
        logic [1:0] pat;
        sel = 2'd3;
        pat = 2'b01;
        issue(1'b1, 1'b0, 4'd7, 32'h77665544, 4'hF);
        issue(1'b0, 1'b1, 4'd7, 32'h0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (busy_m !== pat[i])
                $display("FAIL lat1_busy[%0d]: got %b, expected %b", i, busy_m, pat[i]);
            else passed++;
            @(negedge clk);
        end
        issue(1'b1, 1'b0, 4'd7, 32'h00990000, 4'b0100);
        issue(1'b0, 1'b1, 4'd7, 32'h0, 4'h0);
        idle(3);
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL lat1_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e)
                $display("FAIL lat1_resp: got err=%b rdata=%h cycle=%0d, expected err=%b rdata=%h cycle=%0d",
                         o.err, o.data, o.cyc, e.err, e.data, e.cyc);
            else begin passed++; $display("lat1: err=%b rdata=%h cycle=%0d ok", o.err, o.data, o.cyc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        sel = 2'd0;
        for (int a = 0; a < 16; a++) issue(1'b1, 1'b0, 4'(a), $urandom, 4'hF);
        for (int a = 0; a < 16; a++) begin
            wait_ready();
            issue(1'b0, 1'b1, 4'(a), 32'h0, 4'h0);
        end
        idle(4);
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL b2b_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e)
                $display("FAIL b2b_resp: got err=%b rdata=%h cycle=%0d, expected err=%b rdata=%h cycle=%0d",
                         o.err, o.data, o.cyc, e.err, e.data, e.cyc);
            else begin passed++; $display("b2b: err=%b rdata=%h cycle=%0d ok", o.err, o.data, o.cyc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_abort();
        sel = 2'd2;
        for (int a = 0; a < 4; a++) issue(1'b1, 1'b0, 4'(a), 32'h1000 + 32'(a), 4'hF);
        issue(1'b0, 1'b1, 4'd1, 32'h0, 4'h0);
        wait_ready();
        idle(2);
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL abort_pre_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e)
                $display("FAIL abort_pre_resp: got err=%b rdata=%h cycle=%0d, expected err=%b rdata=%h cycle=%0d",
                         o.err, o.data, o.cyc, e.err, e.data, e.cyc);
            else begin passed++; $display("abort_pre: err=%b rdata=%h cycle=%0d ok", o.err, o.data, o.cyc); end
        end
        exp_q.delete(); obs_q.delete();

        issue(1'b0, 1'b1, 4'd2, 32'h0, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({busy_m, response_m, error_m, rdata_m} !== {3'b000, rv[2]})
            $display("FAIL abort_async: got busy=%b resp=%b err=%b rdata=%h, expected busy=0 resp=0 err=0 rdata=%h",
                     busy_m, response_m, error_m, rdata_m, rv[2]);
        else begin passed++; $display("abort_async: rdata=%h ok", rdata_m); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(8);
        total++;
        if (obs_q.size() != 0)
            $display("FAIL abort_no_resp: got %0d responses, expected 0", obs_q.size());
        else passed++;
        obs_q.delete();

        for (int a = 0; a < 16; a++) begin
            wait_ready();
            issue(1'b0, 1'b1, 4'(a), 32'h0, 4'h0);
        end
        idle(6);
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL abort_post_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e)
                $display("FAIL abort_post_resp: got err=%b rdata=%h cycle=%0d, expected err=%b rdata=%h cycle=%0d",
                         o.err, o.data, o.cyc, e.err, e.data, e.cyc);
            else begin passed++; $display("abort_post: err=%b rdata=%h cycle=%0d ok", o.err, o.data, o.cyc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_error_qualify();
        total++;
        if (qual_errs !== 0)
            $display("FAIL error_qualify: got %0d cycles with error=1 and response=0, expected 0", qual_errs);
        else begin passed++; $display("error_qualify: ok"); end
    endtask

    initial begin
        wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; be = '0; sel = 2'd0;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_read_latency();
        test_byte_enable();
        test_reject();
        test_busy_ignore();
        test_latency_one();
        test_back_to_back();
        test_reset_abort();
        test_error_qualify();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
